// File: rtl/id_exm_skid_regs_if.sv
// ============================================================================
// Module      : id_exm_skid_regs_if
// Description : ID->EXM boundary bundle: decode-side valid/ready beat,
//               EXM-side valid/ready beat, flush and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_exm_skid_regs_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 18
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_rs1;
  logic [XLEN-1:0]   in_rs2;
  logic [XLEN-1:0]   in_imm;
  logic [XLEN-1:0]   in_inst;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_rs1;
  logic [XLEN-1:0]   out_rs2;
  logic [XLEN-1:0]   out_imm;
  logic [XLEN-1:0]   out_inst;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  // Decode/EXM side (drives the beat in, consumes the beat out)
  modport master (
    output flush, in_valid, in_pc, in_rs1, in_rs2, in_imm, in_inst, in_ctrl, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_imm, out_inst, out_ctrl,
           occupancy
  );

  // Pipeline register side
  modport slave (
    input  flush, in_valid, in_pc, in_rs1, in_rs2, in_imm, in_inst, in_ctrl, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_imm, out_inst, out_ctrl,
           occupancy
  );
endinterface

`default_nettype wire

// File: rtl/id_exm_skid_regs.sv
// ============================================================================
// Module      : id_exm_skid_regs
// Description : ID->EXM pipeline register with 2-entry skid buffer, registered
//               ready and flush-to-bubble.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_exm_skid_regs #(
  parameter int                XLEN     = 32,
  parameter int                CTRL_W   = 18,
  parameter logic [XLEN-1:0]   NOP_INST = XLEN'(32'h0000_0013),
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
  input  wire logic           clk,
  input  wire logic           rst,
  id_exm_skid_regs_if.slave   bus
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   inst;
    logic [CTRL_W-1:0] ctrl;
  } beat_t;

  // Bit 0 = main valid, bit 1 = skid valid, so both flags are plain flop bits
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_MAIN  = 2'b01,
    S_BOTH  = 2'b11
  } state_t;

  localparam beat_t c_reset_beat = '{
    pc:   '0,
    rs1:  '0,
    rs2:  '0,
    imm:  '0,
    inst: NOP_INST,
    ctrl: CTRL_NOP
  };

  state_t r_state;
  state_t w_state_nxt;
  beat_t  r_main;
  beat_t  r_skid;
  beat_t  w_in_beat;
  logic   r_in_ready;
  logic   w_main_v;
  logic   w_skid_v;
  logic   w_accept;
  logic   w_drain;
  logic   w_load_in;
  logic   w_load_skid;
  logic   w_skid_to_main;
  logic   w_bubble;

  assign w_in_beat = {bus.in_pc, bus.in_rs1, bus.in_rs2, bus.in_imm, bus.in_inst, bus.in_ctrl};
  assign w_main_v  = r_state[0];
  assign w_skid_v  = r_state[1];
  assign w_accept  = bus.in_valid & r_in_ready;
  assign w_drain   = w_main_v & bus.out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_in      = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    w_bubble       = 1'b0;
    if (bus.flush) begin
      // A beat draining this cycle is already consumed by EXM; the rest die
      w_state_nxt = S_EMPTY;
      w_bubble    = 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_load_in   = 1'b1;
            w_state_nxt = S_MAIN;
          end
        end
        S_MAIN: begin
          if (w_drain) begin
            if (w_accept) begin
              w_load_in = 1'b1;
            end else begin
              w_bubble    = 1'b1;
              w_state_nxt = S_EMPTY;
            end
          end else if (w_accept) begin
            w_load_skid = 1'b1;
            w_state_nxt = S_BOTH;
          end
        end
        S_BOTH: begin
          // in_ready is low here, so no accept can coincide with the refill
          if (w_drain) begin
            w_skid_to_main = 1'b1;
            w_state_nxt    = S_MAIN;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
          w_bubble    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_BOTH);
    end
  end

  // Bubble only rewrites inst/ctrl; the other fields keep their last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= c_reset_beat;
    end else if (w_bubble) begin
      r_main.inst <= NOP_INST;
      r_main.ctrl <= CTRL_NOP;
    end else if (w_load_in) begin
      r_main <= w_in_beat;
    end else if (w_skid_to_main) begin
      r_main <= r_skid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid <= '0;
    end else if (w_load_skid) begin
      r_skid <= w_in_beat;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = w_main_v;
  assign bus.out_pc    = r_main.pc;
  assign bus.out_rs1   = r_main.rs1;
  assign bus.out_rs2   = r_main.rs2;
  assign bus.out_imm   = r_main.imm;
  assign bus.out_inst  = r_main.inst;
  assign bus.out_ctrl  = r_main.ctrl;
  assign bus.occupancy = {w_skid_v, w_main_v & ~w_skid_v};

endmodule

`default_nettype wire

// File: doc/id_exm_skid_regs.md
Name: id_exm_skid_regs

Overview:
- Next-generation ID→EXM pipeline boundary register with a valid/ready handshake, a 2-entry skid buffer, flush-to-bubble and parametrised payload widths.
- Sits between the decode stage (regfile read and immediate gen) and the execute/memory stage.
- Lets EXM back-pressure decode without a combinational ready path.
- On flush (branch/jump redirect) it injects a NOP bubble.

Parameters:
- XLEN, 32, width of pc, rs1, rs2, imm and inst fields.
- CTRL_W, 18, width of packed control bundle {BrUn, BSel, ASel, ALUSel[3:0], MEMWen[3:0], CSRSrc, LDSel[2:0], WBSel[1:0], RegWen}.
- NOP_INST, 32'h0000_0013, instruction word presented while empty or after flush (addi x0,x0,0).
- CTRL_NOP, {CTRL_W{1'b0}}, control bundle presented with a bubble (RegWen=0, MEMWen=0).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- flush, input, 1, kill all held entries and incoming beat this cycle.
- in_valid, input, 1, decode presents a beat.
- in_ready, output, 1, stage can accept; registered, not combinational from out_ready.
- in_pc / in_rs1 / in_rs2 / in_imm / in_inst, input, XLEN each, decode payload.
- in_ctrl, input, CTRL_W, packed control.
- out_valid, output, 1, EXM beat valid.
- out_ready, input, 1, EXM accepts beat.
- out_pc / out_rs1 / out_rs2 / out_imm / out_inst, output, XLEN each, registered payload.
- out_ctrl, output, CTRL_W, registered control.
- occupancy, output, 2, entries held (0..2).

Behaviour:
- Storage:
  - main entry drives outputs directly from flops.
  - skid entry holds one overflow beat.
  - occupancy = main_v + skid_v.
- Handshakes:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
- Reset (async, rst=1):
  - main_v = skid_v = 0, out_valid = 0, in_ready = 1, occupancy = 0.
  - out_inst = NOP_INST, out_ctrl = CTRL_NOP.
  - out_pc, out_rs1, out_rs2, out_imm = 0.
  - Reset asserted mid-transfer discards all entries immediately, with no clock needed.
- Latency: a beat accepted at edge N appears on out_* with out_valid=1 after edge N, provided main was empty or draining. Sustained throughput is 1 beat/cycle when out_ready=1.
- Next-state rules per edge, in priority order:
  1. flush=1:
     - main_v = skid_v = 0; incoming beat dropped even if in_valid=1.
     - out_inst = NOP_INST, out_ctrl = CTRL_NOP; other out_* hold.
     - in_ready = 1 next cycle.
  2. main empty: an accepted beat is loaded into main.
  3. main full, drain, skid empty: an accepted beat replaces main; with no accept, main_v = 0 and outputs go to NOP/CTRL_NOP.
  4. main full, drain, skid full: skid moves to main, skid_v = 0. Accept is impossible because in_ready = 0.
  5. main full, no drain, accept: the beat goes to skid, skid_v = 1.
  6. main full, no drain, no accept: hold everything.
- in_ready is registered as ~skid_v_next (low only while skid is full) and is cleared to 1 by flush or rst.
- While out_valid=1 and out_ready=0, every out_* is stable (AXI-style hold).
- Beat order is strictly FIFO: skid never overtakes main.
- No data-field arithmetic; width changes come from XLEN/CTRL_W only. All out_* are pure flop outputs.
- A flush in the same cycle as drain: the drained beat counts as consumed by EXM, and all remaining entries are killed.

Test Plan:
- Reset/idle:
  - Stimulus: rst pulse asynchronously mid-cycle at t=3ns.
  - Required: out_valid=0, out_inst=32'h13, out_ctrl=0, in_ready=1, occupancy=0 before the next clk edge.
- Streaming:
  - Stimulus: out_ready=1; beats pc=1234, rs1=2345, rs2=3456, imm=4567, inst=1345, ALUSel=3, MEMWen=4'hF, LDSel=2, WBSel=2, RegWen=1 on consecutive cycles with pc+4 each.
  - Required: each beat appears exactly 1 cycle later, no gaps, occupancy≤1.
- Back-pressure:
  - Stimulus: out_ready=0 while sending pc=100, 104, 108.
  - Required: main holds pc=100; skid takes 104; in_ready=0 after the second accept, so 108 stalls on the input; occupancy=2.
  - Then out_ready=1: outputs pc=100, then 104, then 108 in order.
- Flush with full buffer:
  - Stimulus: occupancy=2, flush=1 together with in_valid=1 (pc=200).
  - Required: next cycle out_valid=0, out_inst=32'h13, out_ctrl=0, occupancy=0, in_ready=1; pc=200 never appears.
- Flush+drain same cycle:
  - Stimulus: main=pc 300, out_ready=1, flush=1.
  - Required: pc 300 consumed once, then bubble.
- Parameter sweep:
  - Stimulus: rerun the streaming and back-pressure tests with XLEN=64 and CTRL_W=24.
  - Required: identical ordering and cycle behaviour.
